// File: rtl/conv_window_feeder_if.sv
// Memory-read and window-storage bus of the convolution window feeder.
//   master (feeder side): drives mem_rd_en, mem_addr, we, address, wr_data, re;
//                         receives mem_rd_data.
//   slave  (memory/storage side): the mirror image.
interface conv_window_feeder_if #(
   parameter int unsigned AW = 19
);
   logic          mem_rd_en;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_rd_data;
   logic          we;
   logic [3:0]    address;
   logic [7:0]    wr_data;
   logic          re;

   modport master (
      output mem_rd_en, mem_addr, we, address, wr_data, re,
      input  mem_rd_data
   );

   modport slave (
      input  mem_rd_en, mem_addr, we, address, wr_data, re,
      output mem_rd_data
   );
endinterface

// File: rtl/conv_window_feeder.sv
// Streams 3x3 pixel windows, in raster order of their centre, from a pixel
// memory into a window storage, with zero padding at the image border.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   start           begins a full-frame pass (sampled in IDLE only)
//   ready           downstream can accept the next window
//   bus             memory read (mem_rd_en/mem_addr/mem_rd_data) and
//                   storage write (we/address/wr_data/re) signals
//   counter_col_640 / counter_Row_640   current window centre
//   zero_row, final_row, zero_col, final_col   border flags of the centre
//   busy            pass in progress
//   done            one-cycle pulse after the last window
module conv_window_feeder #(
   parameter int unsigned IMG_W = 640,
   parameter int unsigned IMG_H = 640,
   parameter int unsigned AW    = 19
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        ready,
   conv_window_feeder_if.master bus,
   output logic [14:0] counter_col_640,
   output logic [14:0] counter_Row_640,
   output logic        zero_row,
   output logic        final_row,
   output logic        zero_col,
   output logic        final_col,
   output logic        busy,
   output logic        done
);

   localparam int unsigned CW = 15;
   localparam int unsigned TW = 4;
   localparam logic [CW-1:0] ROW_LAST = CW'(IMG_H - 1);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [TW-1:0] TAP_LAST = TW'(8);

   typedef enum logic [2:0] {IDLE, FETCH, DRAIN, EMIT, WAIT, DONE} state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] tap_q, tap_d;
   logic [CW-1:0] row_q, row_d, col_q, col_d;
   logic          rd_en_q, rd_en_d;
   logic [AW-1:0] addr_q, addr_d;
   logic          we_q, we_d;
   logic [TW-1:0] wa_q, wa_d;
   logic          wvalid_q, wvalid_d;
   logic          re_q, re_d;
   logic          done_q, done_d;
   logic          busy_q, busy_d;
   logic          zr_q, zr_d, fr_q, fr_d, zc_q, zc_d, fc_q, fc_d;

   logic          adv;
   logic          last_centre;
   logic [1:0]    dr, dc;
   logic          row_ok, col_ok, issue;
   logic [CW-1:0] tap_row, tap_col;

   assign last_centre = (row_q == ROW_LAST) && (col_q == COL_LAST);

   // State register and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         tap_q    <= '0;
         row_q    <= '0;
         col_q    <= '0;
         rd_en_q  <= 1'b0;
         addr_q   <= '0;
         we_q     <= 1'b0;
         wa_q     <= '0;
         wvalid_q <= 1'b0;
         re_q     <= 1'b0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
         zr_q     <= 1'b0;
         fr_q     <= 1'b0;
         zc_q     <= 1'b0;
         fc_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         tap_q    <= tap_d;
         row_q    <= row_d;
         col_q    <= col_d;
         rd_en_q  <= rd_en_d;
         addr_q   <= addr_d;
         we_q     <= we_d;
         wa_q     <= wa_d;
         wvalid_q <= wvalid_d;
         re_q     <= re_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
         zr_q     <= zr_d;
         fr_q     <= fr_d;
         zc_q     <= zc_d;
         fc_q     <= fc_d;
      end
   end

   // Next state, and next values of every registered output.
   always_comb begin
      state_d = state_q;
      tap_d   = tap_q;
      row_d   = row_q;
      col_d   = col_q;
      adv     = 1'b0;
      zr_d    = zr_q;
      fr_d    = fr_q;
      zc_d    = zc_q;
      fc_d    = fc_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = FETCH;
               tap_d   = '0;
               row_d   = '0;
               col_d   = '0;
            end
         end
         FETCH: begin
            if (tap_q == TAP_LAST) state_d = DRAIN;
            else                   tap_d   = tap_q + TW'(1);
         end
         DRAIN: state_d = EMIT;
         EMIT: begin
            if (ready) adv = 1'b1;
            else       state_d = WAIT;
         end
         WAIT: begin
            if (ready) adv = 1'b1;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Raster advance of the window centre; the last centre ends the pass.
      if (adv) begin
         if (last_centre) begin
            state_d = DONE;
         end else begin
            state_d = FETCH;
            tap_d   = '0;
            if (col_q == COL_LAST) begin
               col_d = '0;
               row_d = row_q + CW'(1);
            end else begin
               col_d = col_q + CW'(1);
            end
         end
      end

      // Tap geometry for the tap issued next cycle: row/column offsets 0..2.
      case (tap_d)
         TW'(0), TW'(1), TW'(2): dr = 2'd0;
         TW'(3), TW'(4), TW'(5): dr = 2'd1;
         default:                dr = 2'd2;
      endcase
      case (tap_d)
         TW'(0), TW'(3), TW'(6): dc = 2'd0;
         TW'(1), TW'(4), TW'(7): dc = 2'd1;
         default:                dc = 2'd2;
      endcase

      row_ok  = !((dr == 2'd0 && row_d == '0) || (dr == 2'd2 && row_d == ROW_LAST));
      col_ok  = !((dc == 2'd0 && col_d == '0) || (dc == 2'd2 && col_d == COL_LAST));
      tap_row = row_d + CW'(dr) - CW'(1);
      tap_col = col_d + CW'(dc) - CW'(1);
      issue   = (state_d == FETCH);

      // Padded taps issue no read; the address keeps its previous value.
      rd_en_d = issue && row_ok && col_ok;
      addr_d  = rd_en_d ? (AW'(tap_row) * AW'(IMG_W) + AW'(tap_col)) : addr_q;

      // Each FETCH cycle's tap is written one cycle later.
      we_d     = (state_q == FETCH);
      wa_d     = we_d ? tap_q : wa_q;
      wvalid_d = we_d && rd_en_q;

      re_d   = (state_d == EMIT);
      done_d = (state_d == DONE);
      busy_d = (state_d != IDLE);

      // Flags only move when a window starts, so they stay frozen through EMIT/WAIT.
      if (issue) begin
         zr_d = (row_d == '0);
         fr_d = (row_d == ROW_LAST);
         zc_d = (col_d == '0);
         fc_d = (col_d == COL_LAST);
      end
   end

   // Read data is only valid in the write cycle, so it passes straight through.
   assign bus.wr_data   = wvalid_q ? bus.mem_rd_data : 8'h00;
   assign bus.mem_rd_en = rd_en_q;
   assign bus.mem_addr  = addr_q;
   assign bus.we        = we_q;
   assign bus.address   = wa_q;
   assign bus.re        = re_q;

   assign counter_col_640 = col_q;
   assign counter_Row_640 = row_q;
   assign zero_row        = zr_q;
   assign final_row       = fr_q;
   assign zero_col        = zc_q;
   assign final_col       = fc_q;
   assign busy            = busy_q;
   assign done            = done_q;

endmodule

// File: tb/tb_conv_window_feeder.sv
// Directed bench for conv_window_feeder on a 4x3 image whose pixel memory
// returns address+1 one cycle after each read strobe.
module tb_conv_window_feeder;
   localparam int unsigned IMG_W = 4;
   localparam int unsigned IMG_H = 3;
   localparam int unsigned AW    = 19;

   logic        clk   = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        ready = 1'b1;
   logic [14:0] ccol, crow;
   logic        zr, fr, zc, fc, busy, done;

   int checks = 0;
   int errors = 0;

   conv_window_feeder_if #(.AW(AW)) bus ();

   conv_window_feeder #(.IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW)) dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .ready           (ready),
      .bus             (bus),
      .counter_col_640 (ccol),
      .counter_Row_640 (crow),
      .zero_row        (zr),
      .final_row       (fr),
      .zero_col        (zc),
      .final_col       (fc),
      .busy            (busy),
      .done            (done)
   );

   always #5 clk = ~clk;

   // Pixel memory: value = address + 1; 0xEE when not strobed so padding must zero it.
   always @(posedge clk)
      bus.mem_rd_data <= bus.mem_rd_en ? 8'(bus.mem_addr + AW'(1)) : 8'hEE;

   // Observers of the storage side.
   logic [7:0]  win [16];
   logic [14:0] cen_r [16];
   logic [14:0] cen_c [16];
   int wr_cnt, rd_cnt, re_total, overlap;

   always @(negedge clk) begin
      if (bus.we === 1'b1) begin
         win[bus.address] = bus.wr_data;
         wr_cnt++;
      end
      if (bus.mem_rd_en === 1'b1) rd_cnt++;
      if (bus.re === 1'b1) begin
         if (re_total < 16) begin
            cen_r[re_total] = crow;
            cen_c[re_total] = ccol;
         end
         re_total++;
      end
      if (bus.we === 1'b1 && bus.re === 1'b1) overlap++;
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clr_win();
      for (int k = 0; k < 16; k++) win[k] = 8'hFF;
      wr_cnt = 0;
      rd_cnt = 0;
   endtask

   // Taps packed as {t0,t1,...,t8}.
   task automatic chk_win(input string tag, input logic [71:0] e);
      for (int k = 0; k < 9; k++)
         chk($sformatf("%s_tap%0d", tag, k), 32'(win[k]), 32'(e[(8-k)*8 +: 8]));
   endtask

   task automatic wait_re(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (bus.re !== 1'b1 && n < 40);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   localparam logic [71:0] W00 = 72'h00_00_00_00_01_02_00_05_06;
   localparam logic [71:0] W11 = 72'h01_02_03_05_06_07_09_0A_0B;

   initial begin
      int n;
      clr_win();
      re_total = 0;
      overlap  = 0;

      // Reset state
      reset = 1'b1;
      repeat (3) tick();
      chk("rst_busy",  32'(busy), 0);
      chk("rst_done",  32'(done), 0);
      chk("rst_we",    32'(bus.we), 0);
      chk("rst_re",    32'(bus.re), 0);
      chk("rst_rd_en", 32'(bus.mem_rd_en), 0);
      chk("rst_addr",  32'(bus.address), 0);
      chk("rst_cen",   32'({crow, ccol}), 0);
      chk("rst_flags", 32'({zr, fr, zc, fc}), 0);

      // Window (0,0): start on the first cycle after reset
      reset = 1'b0;
      start = 1'b1;
      clr_win();
      re_total = 0;
      overlap  = 0;
      tick();
      start = 1'b0;
      chk("f0_busy",  32'(busy), 1);
      chk("f0_rd_en", 32'(bus.mem_rd_en), 0);
      chk("f0_cen",   32'({crow, ccol}), 0);
      chk("f0_flags", 32'({zr, fr, zc, fc}), 32'b1010);
      wait_re(n);
      chk("w00_latency", 32'(n), 10);
      chk("w00_we_at_re", 32'(bus.we), 0);
      chk_win("w00", W00);
      chk("w00_wr_cnt", 32'(wr_cnt), 9);
      chk("w00_rd_cnt", 32'(rd_cnt), 4);
      chk("w00_flags", 32'({zr, fr, zc, fc}), 32'b1010);

      // Window (0,1) with ready low at EMIT
      clr_win();
      tick();
      ready = 1'b0;
      wait_re(n);
      chk("w01_latency", 32'(n), 10);
      chk("w01_col", 32'(ccol), 1);
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("wait_strobes", 32'({bus.we, bus.re, bus.mem_rd_en}), 0);
         chk("wait_busy", 32'(busy), 1);
         chk("wait_cen", 32'({crow, ccol}), 32'({15'd0, 15'd1}));
         chk("wait_flags", 32'({zr, fr, zc, fc}), 32'b1000);
         tick();
      end
      chk("w01_wr_cnt", 32'(wr_cnt), 9);
      chk("w01_rd_cnt", 32'(rd_cnt), 6);
      clr_win();
      ready = 1'b1;
      tick();
      chk("resume_cen", 32'({crow, ccol}), 32'({15'd0, 15'd2}));
      chk("resume_busy", 32'(busy), 1);

      // Windows (0,2), (0,3)
      wait_re(n);
      chk("w02_latency", 32'(n), 10);
      clr_win();
      tick();
      wait_re(n);
      chk("w03_latency", 32'(n), 10);
      chk("w03_flags", 32'({zr, fr, zc, fc}), 32'b1001);

      // Window (1,0) with a stray start pulse
      clr_win();
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("stray_start_cen", 32'({crow, ccol}), 32'({15'd1, 15'd0}));
      wait_re(n);
      chk("w10_latency", 32'(n), 9);
      chk("w10_flags", 32'({zr, fr, zc, fc}), 32'b0010);

      // Window (1,1): fully interior
      clr_win();
      tick();
      wait_re(n);
      chk("w11_latency", 32'(n), 10);
      chk_win("w11", W11);
      chk("w11_rd_cnt", 32'(rd_cnt), 9);
      chk("w11_flags", 32'({zr, fr, zc, fc}), 0);

      // Remaining windows through (2,3)
      for (int w = 6; w < 12; w++) begin
         clr_win();
         tick();
         wait_re(n);
         chk("tail_latency", 32'(n), 10);
      end
      chk("last_cen", 32'({crow, ccol}), 32'({15'd2, 15'd3}));
      chk("last_flags", 32'({zr, fr, zc, fc}), 32'b0101);
      tick();
      chk("done_pulse", 32'(done), 1);
      chk("done_busy", 32'(busy), 1);
      chk("done_rd_en", 32'(bus.mem_rd_en), 0);
      tick();
      chk("idle_done", 32'(done), 0);
      chk("idle_busy", 32'(busy), 0);
      chk("re_total", 32'(re_total), 12);
      chk("we_re_overlap", 32'(overlap), 0);
      for (int i = 0; i < 12; i++)
         chk($sformatf("centre%0d", i), 32'({cen_r[i], cen_c[i]}),
             32'({15'(i / 4), 15'(i % 4)}));

      // Reset in FETCH cycle 4 of window (0,1)
      clr_win();
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_re(n);
      chk("p2_latency", 32'(n), 10);
      clr_win();
      tick();
      repeat (4) tick();
      chk("pre_rst_col", 32'(ccol), 1);
      reset = 1'b1;
      tick();
      chk("mid_rst_busy",  32'(busy), 0);
      chk("mid_rst_strb",  32'({bus.we, bus.re, bus.mem_rd_en, done}), 0);
      chk("mid_rst_addr",  32'(bus.address), 0);
      chk("mid_rst_cen",   32'({crow, ccol}), 0);
      chk("mid_rst_flags", 32'({zr, fr, zc, fc}), 0);
      reset = 1'b0;
      start = 1'b1;
      clr_win();
      tick();
      start = 1'b0;
      chk("restart_cen", 32'({crow, ccol}), 0);
      chk("restart_flags", 32'({zr, fr, zc, fc}), 32'b1010);
      wait_re(n);
      chk("restart_latency", 32'(n), 10);
      chk_win("restart", W00);
      chk("restart_wr_cnt", 32'(wr_cnt), 9);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/conv_window_feeder.md
CONV_WINDOW_FEEDER -- requirements
Module: conv_window_feeder

Interface
REQ-001 SHALL have parameters: IMG_W, 640, image width in pixels; IMG_H, 640, image height in pixels; AW, 19, memory address width.
REQ-002 SHALL have ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin one full-frame pass; sampled in IDLE only.
- ready  in  1  downstream can accept the next window.
- mem_rd_en  out  1  pixel memory read strobe.
- mem_addr  out  AW  pixel address, row*IMG_W+col.
- mem_rd_data  in  8  pixel, valid exactly 1 cycle after mem_rd_en.
- we  out  1  window-storage write strobe.
- address  out  4  window tap index 0..8.
- wr_data  out  8  tap pixel written to storage.
- re  out  1  one-cycle pulse: storage packs the window.
- counter_col_640  out  15  current window centre column.
- counter_Row_640  out  15  current window centre row.
- zero_row, final_row, zero_col, final_col  out  1 each  border flags of the centre.
- busy  out  1  pass in progress.
- done  out  1  one-cycle pulse after last window.
REQ-003 SHALL use reset reset, synchronous, active-high; clock clk.

Function
REQ-004 SHALL implement FSM states IDLE, FETCH, DRAIN, EMIT, WAIT, DONE.
REQ-005 SHALL go IDLE->FETCH on start=1, clearing centre row=0, col=0; start is ignored in all other states.
REQ-006 SHALL define tap k (0..8) as pixel (row+k/3-1, col+k%3-1), row-major, tap 4 = centre.
REQ-007 SHALL spend 9 cycles in FETCH, issuing tap k in FETCH cycle k: mem_rd_en=1 with mem_addr of the tap when it is in range, mem_rd_en=0 when it is out of range (padding).
REQ-008 SHALL write tap k one cycle after it is issued: we=1, address=k, wr_data=mem_rd_data for in-range taps and 8'h00 for padded taps; writes of taps 0..7 overlap FETCH cycles 1..8, tap 8 is written in the single DRAIN cycle.
REQ-009 SHALL hold counter_col_640, counter_Row_640 and the four flags constant from the first FETCH cycle through EMIT of each window, including the cycle in which address=5.
REQ-010 SHALL set zero_row=(row==0), final_row=(row==IMG_H-1), zero_col=(col==0), final_col=(col==IMG_W-1).
REQ-011 SHALL assert re=1 for exactly one cycle in EMIT, with we=0; re and we SHALL never both be 1.
REQ-012 SHALL, in EMIT: if ready=1, advance the centre and enter FETCH next cycle; if ready=0, enter WAIT and hold everything until ready=1, then advance and enter FETCH.
REQ-013 SHALL advance the centre in raster order: col+1; at col=IMG_W-1, col=0 and row+1.
REQ-014 SHALL, when advancing from centre (IMG_H-1, IMG_W-1), go to DONE instead: done=1 for one cycle, then IDLE. The per-window cost is 11 cycles with ready held high.
REQ-015 SHALL drive busy=1 in every state except IDLE; address SHALL hold its last value when we=0, and we, mem_rd_en, re, done SHALL be 0 outside the cycles defined above.
REQ-016 SHALL compute mem_addr without truncation for IMG_W*IMG_H <= 2^AW and SHALL never issue an out-of-range address.

Reset
REQ-017 SHALL, on reset=1 in any state (including mid-window), enter IDLE next cycle with all outputs 0: row=col=0, address=0, flags 0, busy=0.
REQ-018 SHALL discard any pending read data after reset; start is honoured on the first cycle after reset deasserts.

Verification (IMG_W=4, IMG_H=3, memory pixel = address+1)
- start at centre (0,0) -> taps 0,1,2,3,6 written as 0x00; taps 4,5,7,8 written as 0x01,0x02,0x05,0x06; zero_row=zero_col=1; re 10 cycles after first FETCH.
- centre (1,1), ready=1 -> taps 0x01,0x02,0x03,0x05,0x06,0x07,0x09,0x0A,0x0B, all 9 mem_rd_en pulses, flags all 0.
- ready=0 at EMIT of window 2 for 5 cycles -> FSM in WAIT, counters and flags frozen, no we/re/mem_rd_en; advances 1 cycle after ready=1.
- full pass, ready=1 -> exactly 12 re pulses; centres (0,0)..(2,3) in raster order; final_row=final_col=1 on the last; done 1 cycle later; busy falls.
- reset asserted at FETCH cycle 4 -> next cycle IDLE, all outputs 0; new start restarts at (0,0).
- start pulsed while busy -> no effect on sequence or counters.
